apb_job_master: RTL and testbench
=================================

// Module: apb_job_master
// PURPOSE
//  APB initiator that programs and runs one matrix-multiply job on the systolic-array APB register file.
//  - Accepts a job descriptor over valid/ready: A/B/C base addresses and M/N/P.
//  - Issues APB writes for the six config registers, writes START, polls STATUS.END, then clears START.
//  - Reports completion or error with a one-cycle pulse.
//  - Sits in the host/test subsystem; its APB port drives the accelerator's config_bus slave.
// PARAMETERS
//  ADDR_WIDTH     8     APB paddr width
//  BASE_ADDR      'h00  register-file base offset added to every paddr
//  POLL_GAP       4     idle cycles between consecutive STATUS reads (0 = back-to-back)
//  POLL_LIMIT     1024  max STATUS reads before timeout error (>=1)
// PORTS
//  clk          in   1           single clock (APB pclk = clk)
//  reset        in   1           asynchronous, active-high reset
//  job_valid_i  in   1           descriptor valid
//  job_ready_o  out  1           high only in IDLE; transfer on valid&ready
//  a_addr_i     in   16          matrix A base address
//  b_addr_i     in   16          matrix B base address
//  c_addr_i     in   16          matrix C base address
//  m_i,n_i,p_i  in   16 each     matrix dimensions
//  psel_o       out  1           APB select
//  penable_o    out  1           APB enable
//  pwrite_o     out  1           1 = write, 0 = read
//  paddr_o      out  ADDR_WIDTH  APB address
//  pwdata_o     out  32          write data; zero-extended 16-bit fields
//  prdata_i     in   32          read data
//  pready_i     in   1           slave ready; wait states allowed
//  pslverr_i    in   1           slave error, sampled with pready in ACCESS
//  done_o       out  1           1-cycle pulse: job finished, success or error
//  err_o        out  1           1-cycle pulse with done_o: pslverr or poll timeout
// BEHAVIOUR
//  - Reset values: all outputs 0 except job_ready_o = 1; FSM in IDLE; descriptor regs and counters = 0.
//  - Register map, offsets from BASE_ADDR:
//      0x00 A, 0x04 B, 0x08 C, 0x0C M, 0x10 N, 0x14 P, 0x18 CTRL (bit0 start), 0x1C STATUS (bit0 end).
//  - Descriptor: captured into internal regs on accept; inputs are ignored afterwards.
//  - FSM states: IDLE, SETUP, ACCESS, GAP, DONE.
//    - IDLE -> SETUP on accept. Step counter = 0.
//    - SETUP: psel=1, penable=0; paddr, pwrite and pwdata from step.
//    - SETUP -> ACCESS after exactly 1 cycle.
//    - ACCESS: psel=1, penable=1. Hold all APB outputs stable until pready_i=1.
//    - On pready_i=1 with pslverr_i=1 -> DONE with error. No further transfers; START is not cleared.
//    - On pready_i=1 with pslverr_i=0, advance by step:
//        steps 0-5: config writes A,B,C,M,N,P -> SETUP for the next step.
//        step 6: write CTRL=1 -> SETUP for step 7.
//        step 7: read STATUS. bit0=1 -> SETUP for step 8.
//          bit0=0 and reads < POLL_LIMIT -> GAP (or straight to SETUP when POLL_GAP=0).
//          bit0=0 and reads = POLL_LIMIT -> DONE with error.
//        step 8: write CTRL=0 -> DONE.
//    - GAP: psel=0 for POLL_GAP cycles, then SETUP step 7.
//    - DONE: done_o=1 for 1 cycle (err_o per result), then IDLE.
//  - psel_o and penable_o are 0 outside SETUP/ACCESS; penable never rises without psel in the prior cycle.
//  - Poll counter: clog2(POLL_LIMIT+1) bits; cleared on accept; increments per completed STATUS read.
//  - Latency, zero wait states, END set on first read:
//    - psel rises the cycle after accept.
//    - done_o is high in cycle 19 after the accept edge (9 transfers x 2 cycles + DONE).
//  - Reset mid-job: immediate return to IDLE; APB outputs drop to 0 asynchronously; no done_o pulse.
//  - job_valid_i while busy: ignored (ready=0); no queueing.
// TESTING
//  1. Zero-wait slave, STATUS=1 on first read:
//     - Required order: writes 0x00..0x14 with zero-extended fields, 0x18=1, read 0x1C, write 0x18=0.
//     - done_o=1, err_o=0 at cycle 19.
//  2. pready low for 3 cycles on every transfer:
//     - ACCESS extends by 3 cycles per transfer, with paddr/pwdata stable.
//     - done_o at cycle 19+27=46.
//  3. STATUS=0 for 5 reads, then 1, POLL_GAP=4:
//     - 6 reads, with psel=0 for exactly 4 cycles between them.
//     - Clear write follows; err_o=0.
//  4. POLL_LIMIT=3, STATUS stuck at 0:
//     - Exactly 3 reads, then done_o=1 and err_o=1.
//     - No CTRL=0 write.
//  5. pslverr_i=1 on the M write (0x0C):
//     - Next cycle done_o=1, err_o=1.
//     - No writes to 0x10..0x18 observed.
//  6. reset asserted while in ACCESS of the START write:
//     - psel/penable drop to 0 asynchronously; job_ready_o=1; done_o stays 0.
//     - A new job then runs normally.

Source files
------------

// File: rtl/apb_job_master_if.sv
// Job descriptor handshake plus APB initiator signals for apb_job_master.
// Latency: none (wires only).
// Backpressure: job_ready_o gates descriptor transfer; pready_i stretches APB ACCESS.
interface apb_job_master_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  job_valid_i;
    logic                  job_ready_o;
    logic [15:0]           a_addr_i;
    logic [15:0]           b_addr_i;
    logic [15:0]           c_addr_i;
    logic [15:0]           m_i;
    logic [15:0]           n_i;
    logic [15:0]           p_i;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [31:0]           pwdata_o;
    logic [31:0]           prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;
    logic                  done_o;
    logic                  err_o;

    modport master (
        input  job_valid_i, a_addr_i, b_addr_i, c_addr_i, m_i, n_i, p_i,
        input  prdata_i, pready_i, pslverr_i,
        output job_ready_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output done_o, err_o
    );

    modport slave (
        output job_valid_i, a_addr_i, b_addr_i, c_addr_i, m_i, n_i, p_i,
        output prdata_i, pready_i, pslverr_i,
        input  job_ready_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  done_o, err_o
    );
endinterface

// File: rtl/apb_job_master.sv
// APB initiator: programs one matmul job (6 config writes, START, poll STATUS.END, clear START).
// Latency: 19 cycles accept-to-done with zero wait states and END set on the first poll.
// Backpressure: job_ready_o only in IDLE; pready_i low holds ACCESS with all APB outputs stable.
module apb_job_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 'h00,
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    apb_job_master_if.master    bus
);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

    // Step numbering: 0-5 config writes, 6 START, 7 STATUS poll, 8 START clear.
    localparam logic [3:0] STEP_START = 4'd6;
    localparam logic [3:0] STEP_POLL  = 4'd7;
    localparam logic [3:0] STEP_CLEAR = 4'd8;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [PW-1:0]   poll_inc;
    logic [GW-1:0]   gap_q, gap_d;
    logic            err_q, err_d;
    logic [15:0]     a_q, b_q, c_q, m_q, n_q, p_q;
    logic            accept;
    logic [7:0]      step_off;
    logic [31:0]     step_wdata;

    assign accept   = bus.job_valid_i && (state_q == S_IDLE);
    assign poll_inc = poll_q + 1'b1;

    // Register offset for the current step; CTRL is revisited by the clear step.
    always_comb begin
        step_off = 8'h00;
        case (step_q)
            STEP_POLL:  step_off = 8'h1C;
            STEP_CLEAR: step_off = 8'h18;
            default:    step_off = {2'b00, step_q, 2'b00};
        endcase
    end

    // Write data for the current step; descriptor fields are zero-extended.
    always_comb begin
        step_wdata = 32'h0;
        case (step_q)
            4'd0:       step_wdata = {16'h0, a_q};
            4'd1:       step_wdata = {16'h0, b_q};
            4'd2:       step_wdata = {16'h0, c_q};
            4'd3:       step_wdata = {16'h0, m_q};
            4'd4:       step_wdata = {16'h0, n_q};
            4'd5:       step_wdata = {16'h0, p_q};
            STEP_START: step_wdata = 32'h1;
            default:    step_wdata = 32'h0;
        endcase
    end

    // State, step, poll and gap registers; reset drops the APB port immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    // Descriptor capture on accept; inputs are ignored for the rest of the job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0; b_q <= '0; c_q <= '0;
            m_q <= '0; n_q <= '0; p_q <= '0;
        end else if (accept) begin
            a_q <= bus.a_addr_i; b_q <= bus.b_addr_i; c_q <= bus.c_addr_i;
            m_q <= bus.m_i;      n_q <= bus.n_i;      p_q <= bus.p_i;
        end
    end

    // Next-state and output decode; APB address/data are only driven in SETUP/ACCESS.
    always_comb begin
        state_d         = state_q;
        step_d          = step_q;
        poll_d          = poll_q;
        gap_d           = gap_q;
        err_d           = err_q;
        bus.job_ready_o = 1'b0;
        bus.psel_o      = 1'b0;
        bus.penable_o   = 1'b0;
        bus.pwrite_o    = 1'b0;
        bus.paddr_o     = '0;
        bus.pwdata_o    = 32'h0;
        bus.done_o      = 1'b0;
        bus.err_o       = 1'b0;

        if (state_q == S_SETUP || state_q == S_ACCESS) begin
            bus.psel_o   = 1'b1;
            bus.pwrite_o = (step_q != STEP_POLL);
            bus.paddr_o  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(step_off);
            bus.pwdata_o = step_wdata;
        end

        case (state_q)
            S_IDLE: begin
                bus.job_ready_o = 1'b1;
                if (bus.job_valid_i) begin
                    state_d = S_SETUP;
                    step_d  = '0;
                    poll_d  = '0;
                    gap_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                bus.penable_o = 1'b1;
                if (bus.pready_i) begin
                    if (bus.pslverr_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (step_q == STEP_CLEAR) begin
                        state_d = S_DONE;
                    end else if (step_q == STEP_POLL) begin
                        poll_d = poll_inc;
                        if (bus.prdata_i[0]) begin
                            step_d  = STEP_CLEAR;
                            state_d = S_SETUP;
                        end else if (poll_inc >= PW'(POLL_LIMIT)) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else if (POLL_GAP == 0) begin
                            state_d = S_SETUP;
                        end else begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_SETUP;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                bus.err_o  = err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_apb_job_master.sv
// Bench for apb_job_master: transaction-level model of the expected APB sequence and done timing.
// Latency: checks accept-to-done cycle counts against the model and hand-computed literals.
// Backpressure: bench slave inserts configurable wait states, STATUS misses and slave errors.
module tb_apb_job_master;
    localparam int MAIN_GAP   = 4;
    localparam int MAIN_LIMIT = 1024;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_job_master_if #(.ADDR_WIDTH(8)) bus ();
    apb_job_master_if #(.ADDR_WIDTH(8)) bus2 ();

    apb_job_master #(.ADDR_WIDTH(8), .BASE_ADDR(0), .POLL_GAP(MAIN_GAP), .POLL_LIMIT(MAIN_LIMIT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    apb_job_master #(.ADDR_WIDTH(8), .BASE_ADDR(0), .POLL_GAP(0), .POLL_LIMIT(3)) dut_lim (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // Second instance sees a slave whose STATUS never reports END.
    assign bus2.pready_i  = 1'b1;
    assign bus2.prdata_i  = 32'h0;
    assign bus2.pslverr_i = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave behaviour and model results
    int         cfg_wait = 0;
    int         cfg_zeros = 0;
    bit         cfg_err_en = 0;
    logic [7:0] cfg_err_addr = 8'h00;
    xfer_t      exp_q[$];
    bit         exp_err;
    int         exp_lat;

    // Expected transfer list and accept-to-done latency, from the job rules.
    task automatic build_model(input logic [15:0] a, b, c, m, n, p);
        logic [15:0] f[6];
        int lat;
        bit stop;
        f = '{a, b, c, m, n, p};
        exp_q.delete();
        exp_err = 0;
        lat = 0;
        stop = 0;
        for (int i = 0; i < 6 && !stop; i++) begin
            exp_q.push_back('{1'b1, 8'(i * 4), {16'h0, f[i]}});
            lat += 2 + cfg_wait;
            if (cfg_err_en && cfg_err_addr == 8'(i * 4)) begin exp_err = 1; stop = 1; end
        end
        if (!stop) begin
            exp_q.push_back('{1'b1, 8'h18, 32'h1});
            lat += 2 + cfg_wait;
            if (cfg_err_en && cfg_err_addr == 8'h18) begin exp_err = 1; stop = 1; end
        end
        if (!stop) begin
            for (int r = 1; r <= MAIN_LIMIT; r++) begin
                exp_q.push_back('{1'b0, 8'h1C, 32'h0});
                lat += 2 + cfg_wait;
                if (r > cfg_zeros) break;
                if (r == MAIN_LIMIT) begin exp_err = 1; stop = 1; break; end
                lat += MAIN_GAP;
            end
        end
        if (!stop) begin
            exp_q.push_back('{1'b1, 8'h18, 32'h0});
            lat += 2 + cfg_wait;
        end
        exp_lat = lat + 1;
    endtask

    // Compare/slave process state
    int          cyc = 0;
    int          accept_cyc = 0;
    bit          active = 0;
    bit          done_seen = 0;
    int          done_lat = 0;
    logic        done_err = 1'b0;
    int          status_reads = 0;
    int          acc_cnt = 0;
    bit          watch = 0;
    int          idle_gap = 0;
    logic        prev_psel = 1'b0;
    logic        prev_wait = 1'b0;
    logic        prev_wr = 1'b0;
    logic [7:0]  prev_addr = 8'h0;
    logic [31:0] prev_wdata = 32'h0;

    // Per-cycle comparison against the model, plus the bench slave response.
    always @(negedge clk) begin
        xfer_t e;
        logic  comp;
        cyc++;
        if (reset) begin
            active = 0;
            exp_q.delete();
            bus.pready_i = 1'b0;
            bus.pslverr_i = 1'b0;
            bus.prdata_i = 32'h0;
            prev_psel = 1'b0;
            prev_wait = 1'b0;
            acc_cnt = 0;
            watch = 0;
        end else begin
            if (!active) begin
                chk("done_idle", bus.done_o, 1'b0);
                chk("psel_idle", bus.psel_o, 1'b0);
            end else if (bus.done_o) begin
                chk("done_err", bus.err_o, exp_err);
                chk("done_latency", cyc - accept_cyc, exp_lat);
                chk("leftover_xfers", exp_q.size(), 0);
                done_lat = cyc - accept_cyc;
                done_err = bus.err_o;
                done_seen = 1;
                active = 0;
            end
            if (bus.err_o) chk("err_without_done", bus.done_o, 1'b1);
            if (active && cyc > accept_cyc) chk("ready_busy", bus.job_ready_o, 1'b0);
            if (bus.penable_o) chk("penable_after_psel", {prev_psel, bus.psel_o}, 2'b11);
            if (prev_wait) begin
                chk("hold_ctrl", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o},
                    {2'b11, prev_wr, prev_addr});
                chk("hold_wdata", bus.pwdata_o, prev_wdata);
            end
            if (watch) begin
                if (bus.psel_o) begin
                    chk("poll_gap", idle_gap, MAIN_GAP);
                    watch = 0;
                end else begin
                    idle_gap++;
                end
            end

            if (bus.psel_o && bus.penable_o) begin
                bus.pready_i = (acc_cnt >= cfg_wait);
                acc_cnt++;
            end else begin
                bus.pready_i = 1'b0;
                acc_cnt = 0;
            end
            bus.prdata_i  = (status_reads >= cfg_zeros) ? 32'h1 : 32'h0;
            bus.pslverr_i = cfg_err_en && bus.pready_i && (bus.paddr_o == cfg_err_addr);
            comp = bus.psel_o && bus.penable_o && bus.pready_i;

            if (comp) begin
                acc_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("extra_xfer", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_dir", bus.pwrite_o, e.wr);
                    chk("xfer_addr", bus.paddr_o, e.addr);
                    if (e.wr) chk("xfer_wdata", bus.pwdata_o, e.data);
                end
                if (!bus.pwrite_o && bus.paddr_o == 8'h1C) begin
                    status_reads++;
                    if (!bus.prdata_i[0]) begin
                        watch = 1;
                        idle_gap = 0;
                    end
                end
            end
            prev_wait  = bus.psel_o && bus.penable_o && !bus.pready_i;
            prev_psel  = bus.psel_o;
            prev_wr    = bus.pwrite_o;
            prev_addr  = bus.paddr_o;
            prev_wdata = bus.pwdata_o;

            if (bus.job_valid_i && bus.job_ready_o) begin
                accept_cyc = cyc;
                active = 1;
                status_reads = 0;
            end
        end
    end

    // Observer for the POLL_LIMIT=3 instance.
    int   c2 = 0, acc2 = 0, reads2 = 0, ctrl0_2 = 0, dones2 = 0, lat2 = 0;
    logic err2 = 1'b0;
    always @(negedge clk) begin
        c2++;
        if (!reset) begin
            if (bus2.job_valid_i && bus2.job_ready_o) acc2 = c2;
            if (bus2.psel_o && bus2.penable_o) begin
                if (!bus2.pwrite_o && bus2.paddr_o == 8'h1C) reads2++;
                if (bus2.pwrite_o && bus2.paddr_o == 8'h18 && bus2.pwdata_o == 32'h0) ctrl0_2++;
            end
            if (bus2.done_o) begin
                dones2++;
                err2 = bus2.err_o;
                lat2 = c2 - acc2;
            end
        end
    end

    task automatic start_job(input logic [15:0] a, b, c, m, n, p, input int hold);
        build_model(a, b, c, m, n, p);
        done_seen = 0;
        @(posedge clk); #1;
        bus.a_addr_i = a; bus.b_addr_i = b; bus.c_addr_i = c;
        bus.m_i = m; bus.n_i = n; bus.p_i = p;
        bus.job_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.a_addr_i = 16'hFFFF; bus.b_addr_i = 16'hFFFF; bus.c_addr_i = 16'hFFFF;
        bus.m_i = 16'hFFFF; bus.n_i = 16'hFFFF; bus.p_i = 16'hFFFF;
        bus.job_valid_i = (hold > 0);
        repeat (hold) @(posedge clk);
        #1 bus.job_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && !done_seen; i++) @(negedge clk);
        chk(name, done_seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1;
        bus.job_valid_i = 1'b0;
        bus.a_addr_i = 16'h0; bus.b_addr_i = 16'h0; bus.c_addr_i = 16'h0;
        bus.m_i = 16'h0; bus.n_i = 16'h0; bus.p_i = 16'h0;
        bus2.job_valid_i = 1'b0;
        bus2.a_addr_i = 16'h11; bus2.b_addr_i = 16'h22; bus2.c_addr_i = 16'h33;
        bus2.m_i = 16'h2; bus2.n_i = 16'h2; bus2.p_i = 16'h2;
        #1;
        chk("rst_ready", bus.job_ready_o, 1'b1);
        chk("rst_apb", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o}, 0);
        chk("rst_wdata", bus.pwdata_o, 32'h0);
        chk("rst_done_err", {bus.done_o, bus.err_o}, 2'b00);
        #21 reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: zero-wait slave, END on first read
        start_job(16'hF00D, 16'h1234, 16'h8001, 16'd3, 16'd4, 16'd5, 0);
        wait_done("t1_done_seen");
        chk("t1_latency", done_lat, 19);
        chk("t1_err", done_err, 1'b0);

        // 2: three wait states on every transfer
        cfg_wait = 3;
        start_job(16'h0100, 16'h0200, 16'h0300, 16'd8, 16'd8, 16'd8, 0);
        wait_done("t2_done_seen");
        chk("t2_latency", done_lat, 46);
        cfg_wait = 0;

        // 3: five STATUS misses, gap of four idle cycles; valid held while busy
        cfg_zeros = 5;
        start_job(16'hA5A5, 16'h5A5A, 16'hC3C3, 16'd16, 16'd1, 16'd7, 5);
        wait_done("t3_done_seen");
        chk("t3_latency", done_lat, 49);
        chk("t3_reads", status_reads, 6);
        chk("t3_err", done_err, 1'b0);
        cfg_zeros = 0;

        // 4: POLL_LIMIT=3 instance, STATUS stuck at 0
        @(posedge clk); #1 bus2.job_valid_i = 1'b1;
        @(posedge clk); #1 bus2.job_valid_i = 1'b0;
        for (int i = 0; i < 100 && dones2 == 0; i++) @(negedge clk);
        chk("t4_dones", dones2, 1);
        chk("t4_reads", reads2, 3);
        chk("t4_no_clear", ctrl0_2, 0);
        chk("t4_err", err2, 1'b1);
        chk("t4_latency", lat2, 21);

        // 5: slave error on the M write
        cfg_err_en = 1;
        cfg_err_addr = 8'h0C;
        start_job(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 0);
        wait_done("t5_done_seen");
        chk("t5_latency", done_lat, 9);
        chk("t5_err", done_err, 1'b1);
        cfg_err_en = 0;
        repeat (5) @(negedge clk);

        // 6: reset during the START write ACCESS, then a clean job
        cfg_wait = 2;
        start_job(16'h0700, 16'h0800, 16'h0900, 16'd2, 16'd3, 16'd4, 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.psel_o && bus.penable_o && bus.pwrite_o && bus.paddr_o == 8'h18) begin
                found = 1;
                break;
            end
        end
        chk("t6_reach_start", found, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6_apb_drop", {bus.psel_o, bus.penable_o}, 2'b00);
        chk("t6_ready", bus.job_ready_o, 1'b1);
        chk("t6_done", bus.done_o, 1'b0);
        @(negedge clk); #2 reset = 1'b0;
        cfg_wait = 0;
        repeat (4) @(posedge clk);
        start_job(16'h7777, 16'h8888, 16'h9999, 16'd1, 16'd2, 16'd3, 0);
        wait_done("t6_done_seen");
        chk("t6_latency", done_lat, 19);
        chk("t6_err", done_err, 1'b0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
